// File: rtl/memory_bus_if.sv
// ---------------------------------------------------------------------------
// memory_bus_if -- CPU-side request/response bundle for memory_bus.
//
// Signals:
//   address      CPU byte address, sampled with a start strobe
//   data_in      CPU write data
//   data_out     CPU read data (registered in the bus controller)
//   byte_access  1 = byte transfer, 0 = word transfer
//   sign_extend  1 = sign-extend byte reads into [15:8]
//   read_start   single-cycle read request strobe
//   write_start  single-cycle write request strobe
//   busy         transaction in progress
//   done         one-cycle completion pulse
//   bus_error    error flag, only meaningful while done = 1
//
// Modports: master (CPU side), slave (memory_bus side).
// ---------------------------------------------------------------------------
interface memory_bus_if;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        byte_access;
    logic        sign_extend;
    logic        read_start;
    logic        write_start;
    logic        busy;
    logic        done;
    logic        bus_error;

    modport master (
        output address, data_in, byte_access, sign_extend, read_start, write_start,
        input  data_out, busy, done, bus_error
    );

    modport slave (
        input  address, data_in, byte_access, sign_extend, read_start, write_start,
        output data_out, busy, done, bus_error
    );
endinterface

// File: rtl/memory_bus.sv
// ---------------------------------------------------------------------------
// memory_bus -- bridges a 16-bit CPU request port onto a 4K-word RAM and a
// 256-entry IO window, with byte/word transfers, byte-lane write masks,
// optional sign extension of byte reads and error reporting for misaligned,
// unmapped or conflicting requests.
//
// Ports:
//   clk               system clock, all state on the rising edge
//   reset_n           asynchronous active-low reset
//   bus               CPU-side request/response (memory_bus_if.slave)
//   ram_address       RAM word index (latched address[11:0])
//   ram_data_in       RAM write data (byte writes replicated on both lanes)
//   ram_data_out      RAM read data, captured two edges after acceptance
//   ram_write_mask    active-low byte-lane enables, 2'b11 when not writing
//   ram_write_enable  one-cycle RAM write strobe
//   io_address        IO register index (latched address[7:0])
//   io_data_out       IO write data
//   io_data_in        IO read data
//   io_write_enable   one-cycle IO write strobe
//   io_read_strobe    one-cycle IO read strobe
// ---------------------------------------------------------------------------
module memory_bus (
    input  logic               clk,
    input  logic               reset_n,
    memory_bus_if.slave        bus,
    output logic [11:0]        ram_address,
    output logic [15:0]        ram_data_in,
    input  logic [15:0]        ram_data_out,
    output logic [1:0]         ram_write_mask,
    output logic               ram_write_enable,
    output logic [7:0]         io_address,
    output logic [15:0]        io_data_out,
    input  logic [15:0]        io_data_in,
    output logic               io_write_enable,
    output logic               io_read_strobe
);

    typedef enum logic [2:0] {
        IDLE,
        RAM_READ,
        RAM_CAPTURE,
        RAM_WRITE,
        IO_ACCESS,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [11:0] addr_q;
    logic [15:0] wdata_q;
    logic        byte_q;
    logic        sext_q;
    logic        write_q;
    logic        io_q;
    logic        err_q;

    logic        accept;
    logic        hit_ram;
    logic        hit_io;
    logic        req_err;

    // Byte reads select the lane addressed by bit 0 and land in [7:0].
    function automatic logic [15:0] read_format(input logic [15:0] raw,
                                                input logic        byte_acc,
                                                input logic        sext,
                                                input logic        odd);
        logic signed [7:0]  sel;
        logic signed [15:0] ext;
        if (!byte_acc)
            return raw;
        sel = odd ? raw[15:8] : raw[7:0];
        ext = sel;
        return sext ? ext : {8'h00, sel};
    endfunction

    assign accept  = (state == IDLE) && (bus.read_start || bus.write_start);
    assign hit_ram = (bus.address[15:12] == 4'h0);
    assign hit_io  = (bus.address[15:8] == 8'hFF);
    assign req_err = (bus.read_start && bus.write_start)
                   || (!bus.byte_access && bus.address[0])
                   || !(hit_ram || hit_io);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            byte_q       <= 1'b0;
            sext_q       <= 1'b0;
            write_q      <= 1'b0;
            io_q         <= 1'b0;
            err_q        <= 1'b0;
            bus.data_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= bus.address[11:0];
                wdata_q <= bus.data_in;
                byte_q  <= bus.byte_access;
                sext_q  <= bus.sign_extend;
                write_q <= bus.write_start;
                io_q    <= hit_io;
                err_q   <= req_err;
            end
            // IO transactions share the capture state; writes pass through it
            // without touching data_out.
            if (state == RAM_CAPTURE && !write_q)
                bus.data_out <= read_format(io_q ? io_data_in : ram_data_out,
                                            byte_q, sext_q, addr_q[0]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nxt = DONE;
                    else if (hit_io)
                        state_nxt = IO_ACCESS;
                    else if (bus.write_start)
                        state_nxt = RAM_WRITE;
                    else
                        state_nxt = RAM_READ;
                end
            end
            RAM_READ:    state_nxt = RAM_CAPTURE;
            RAM_CAPTURE: state_nxt = DONE;
            RAM_WRITE:   state_nxt = DONE;
            IO_ACCESS:   state_nxt = RAM_CAPTURE;
            DONE:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.bus_error = (state == DONE) && err_q;

    assign ram_address      = addr_q;
    assign ram_data_in      = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
    assign ram_write_enable = (state == RAM_WRITE);
    assign ram_write_mask   = !ram_write_enable ? 2'b11 :
                              !byte_q           ? 2'b00 :
                              addr_q[0]         ? 2'b01 : 2'b10;

    assign io_address      = addr_q[7:0];
    assign io_data_out     = ram_data_in;
    assign io_write_enable = (state == IO_ACCESS) && write_q;
    assign io_read_strobe  = (state == IO_ACCESS) && !write_q;

endmodule

// File: tb/tb_memory_bus.sv
// ---------------------------------------------------------------------------
// tb_memory_bus -- directed bench for memory_bus with a synchronous RAM model
// and a constant IO read source.
// ---------------------------------------------------------------------------
module tb_memory_bus;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] ram_address;
    logic [15:0] ram_data_in;
    logic [15:0] ram_data_out = 16'h0000;
    logic [1:0]  ram_write_mask;
    logic        ram_write_enable;
    logic [7:0]  io_address;
    logic [15:0] io_data_out;
    logic [15:0] io_data_in = 16'h5A5A;
    logic        io_write_enable;
    logic        io_read_strobe;

    logic [15:0] mem [0:4095] = '{default: 16'h0000};

    int checks = 0;
    int failures = 0;

    // Results of the last run_txn
    int          r_lat;
    logic        r_err;
    int          r_we_cnt;
    int          r_iow_cnt;
    int          r_ior_cnt;
    logic [1:0]  r_mask;
    logic [15:0] r_wdata;
    logic [11:0] r_raddr;
    logic [7:0]  r_ioaddr;
    logic [15:0] r_iodata;
    logic        r_mask_idle_bad;
    logic        r_post_done;
    logic        r_post_busy;

    always #5 clk = ~clk;

    memory_bus_if bus_if ();

    memory_bus dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus_if),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out),
        .ram_write_mask   (ram_write_mask),
        .ram_write_enable (ram_write_enable),
        .io_address       (io_address),
        .io_data_out      (io_data_out),
        .io_data_in       (io_data_in),
        .io_write_enable  (io_write_enable),
        .io_read_strobe   (io_read_strobe)
    );

    // Synchronous RAM: one edge to register the read word, active-low lanes.
    always @(posedge clk) begin
        if (ram_write_enable) begin
            if (!ram_write_mask[0]) mem[ram_address][7:0]  <= ram_data_in[7:0];
            if (!ram_write_mask[1]) mem[ram_address][15:8] <= ram_data_in[15:8];
        end
        ram_data_out <= mem[ram_address];
    end

    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, input logic b, input logic sx);
        @(negedge clk);
        bus_if.address     = a;
        bus_if.data_in     = d;
        bus_if.byte_access = b;
        bus_if.sign_extend = sx;
        bus_if.read_start  = rd;
        bus_if.write_start = wr;
        @(posedge clk);
        #1;
        bus_if.read_start  = 1'b0;
        bus_if.write_start = 1'b0;
        r_lat = -1; r_err = 1'b0; r_we_cnt = 0; r_iow_cnt = 0; r_ior_cnt = 0;
        r_mask = 2'b11; r_wdata = '0; r_raddr = '0; r_ioaddr = '0; r_iodata = '0;
        r_mask_idle_bad = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) r_raddr = ram_address;
            if (ram_write_enable) begin
                r_we_cnt++;
                r_mask  = ram_write_mask;
                r_wdata = ram_data_in;
            end else if (ram_write_mask !== 2'b11) begin
                r_mask_idle_bad = 1'b1;
            end
            if (io_write_enable) begin
                r_iow_cnt++;
                r_ioaddr = io_address;
                r_iodata = io_data_out;
            end
            if (io_read_strobe) begin
                r_ior_cnt++;
                r_ioaddr = io_address;
            end
            if (bus_if.done) begin
                r_lat = i;
                r_err = bus_if.bus_error;
                break;
            end
        end
        @(negedge clk);
        r_post_done = bus_if.done;
        r_post_busy = bus_if.busy;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.bus_error !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got busy=%b done=%b err=%b exp 0 0 0", bus_if.busy, bus_if.done, bus_if.bus_error); end
        checks++; if (bus_if.data_out !== 16'h0000) begin
            failures++; $display("FAIL reset_data_out got=%h exp=0000", bus_if.data_out); end
        checks++; if (ram_write_enable !== 1'b0 || ram_write_mask !== 2'b11 || io_write_enable !== 1'b0 || io_read_strobe !== 1'b0) begin
            failures++; $display("FAIL reset_strobes got we=%b mask=%b iow=%b ior=%b exp 0 11 0 0", ram_write_enable, ram_write_mask, io_write_enable, io_read_strobe); end
        checks++; if (ram_address !== 12'h000 || io_address !== 8'h00) begin
            failures++; $display("FAIL reset_addr got ram=%h io=%h exp 000 00", ram_address, io_address); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_word_rw();
        run_txn(1'b0, 1'b1, 16'h0100, 16'h1234, 1'b0, 1'b0);
        checks++; if (r_lat !== 2 || r_err !== 1'b0) begin
            failures++; $display("FAIL word_wr_done got lat=%0d err=%b exp lat=2 err=0", r_lat, r_err); end
        checks++; if (r_we_cnt !== 1 || r_mask !== 2'b00 || r_wdata !== 16'h1234 || r_mask_idle_bad !== 1'b0) begin
            failures++; $display("FAIL word_wr_ram got we=%0d mask=%b data=%h idle_bad=%b exp 1 00 1234 0", r_we_cnt, r_mask, r_wdata, r_mask_idle_bad); end
        checks++; if (r_post_done !== 1'b0 || r_post_busy !== 1'b0) begin
            failures++; $display("FAIL word_wr_after got done=%b busy=%b exp 0 0", r_post_done, r_post_busy); end
        run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0);
        checks++; if (r_lat !== 3 || r_err !== 1'b0 || r_we_cnt !== 0) begin
            failures++; $display("FAIL word_rd_done got lat=%0d err=%b we=%0d exp 3 0 0", r_lat, r_err, r_we_cnt); end
        checks++; if (r_raddr !== 12'h100) begin
            failures++; $display("FAIL word_rd_addr got=%h exp=100", r_raddr); end
        checks++; if (bus_if.data_out !== 16'h1234) begin
            failures++; $display("FAIL word_rd_data got=%h exp=1234", bus_if.data_out); end
    endtask

    task automatic test_byte_rw();
        run_txn(1'b0, 1'b1, 16'h0101, 16'h77AB, 1'b1, 1'b0);
        checks++; if (r_lat !== 2 || r_we_cnt !== 1 || r_mask !== 2'b01 || r_wdata !== 16'hABAB) begin
            failures++; $display("FAIL byte_wr_odd got lat=%0d we=%0d mask=%b data=%h exp 2 1 01 abab", r_lat, r_we_cnt, r_mask, r_wdata); end
        run_txn(1'b1, 1'b0, 16'h0101, 16'h0000, 1'b1, 1'b1);
        checks++; if (r_lat !== 3 || bus_if.data_out !== 16'hFFAB) begin
            failures++; $display("FAIL byte_rd_sext got lat=%0d data=%h exp 3 ffab", r_lat, bus_if.data_out); end
        run_txn(1'b1, 1'b0, 16'h0101, 16'h0000, 1'b1, 1'b0);
        checks++; if (bus_if.data_out !== 16'h00AB) begin
            failures++; $display("FAIL byte_rd_zext got=%h exp=00ab", bus_if.data_out); end
        run_txn(1'b0, 1'b1, 16'h0200, 16'h80C3, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 16'h0200, 16'h1134, 1'b1, 1'b0);
        checks++; if (r_mask !== 2'b10 || r_wdata !== 16'h3434) begin
            failures++; $display("FAIL byte_wr_even got mask=%b data=%h exp 10 3434", r_mask, r_wdata); end
        run_txn(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b1);
        checks++; if (bus_if.data_out !== 16'h0034) begin
            failures++; $display("FAIL byte_rd_even_pos got=%h exp=0034", bus_if.data_out); end
        run_txn(1'b1, 1'b0, 16'h0201, 16'h0000, 1'b1, 1'b1);
        checks++; if (bus_if.data_out !== 16'h0000) begin
            failures++; $display("FAIL byte_rd_other_word got=%h exp=0000", bus_if.data_out); end
        run_txn(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b1);
        checks++; if (bus_if.data_out !== 16'h8034) begin
            failures++; $display("FAIL word_rd_ignores_sext got=%h exp=8034", bus_if.data_out); end
    endtask

    task automatic test_errors();
        run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 16'h0103, 16'h0000, 1'b0, 1'b0);
        checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_we_cnt !== 0) begin
            failures++; $display("FAIL err_misalign got lat=%0d err=%b we=%0d exp 1 1 0", r_lat, r_err, r_we_cnt); end
        checks++; if (bus_if.data_out !== 16'h1234 || r_post_done !== 1'b0 || r_post_busy !== 1'b0) begin
            failures++; $display("FAIL err_misalign_hold got data=%h done=%b busy=%b exp 1234 0 0", bus_if.data_out, r_post_done, r_post_busy); end
        run_txn(1'b0, 1'b1, 16'h2000, 16'hBEEF, 1'b1, 1'b0);
        checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_we_cnt !== 0 || r_iow_cnt !== 0) begin
            failures++; $display("FAIL err_unmapped got lat=%0d err=%b we=%0d iow=%0d exp 1 1 0 0", r_lat, r_err, r_we_cnt, r_iow_cnt); end
        run_txn(1'b1, 1'b1, 16'h0100, 16'h5555, 1'b0, 1'b0);
        checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_we_cnt !== 0) begin
            failures++; $display("FAIL err_both_strobes got lat=%0d err=%b we=%0d exp 1 1 0", r_lat, r_err, r_we_cnt); end
        checks++; if (bus_if.data_out !== 16'h1234) begin
            failures++; $display("FAIL err_data_hold got=%h exp=1234", bus_if.data_out); end
        run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0);
        checks++; if (r_err !== 1'b0 || bus_if.bus_error !== 1'b0) begin
            failures++; $display("FAIL err_clears got err=%b now=%b exp 0 0", r_err, bus_if.bus_error); end
    endtask

    task automatic test_busy_ignore();
        int done_cnt;
        int we_cnt;
        done_cnt = 0;
        we_cnt = 0;
        @(negedge clk);
        bus_if.address = 16'h0100; bus_if.byte_access = 1'b0; bus_if.sign_extend = 1'b0;
        bus_if.read_start = 1'b1;
        @(posedge clk);
        #1 bus_if.read_start = 1'b0;
        @(negedge clk);
        if (bus_if.done) done_cnt++;
        bus_if.data_in = 16'hFFFF;
        bus_if.write_start = 1'b1;
        @(posedge clk);
        #1 bus_if.write_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.done) done_cnt++;
            if (ram_write_enable) we_cnt++;
        end
        checks++; if (done_cnt !== 1 || we_cnt !== 0) begin
            failures++; $display("FAIL busy_ignore got done=%0d we=%0d exp 1 0", done_cnt, we_cnt); end
        checks++; if (bus_if.data_out !== 16'h1234) begin
            failures++; $display("FAIL busy_ignore_data got=%h exp=1234", bus_if.data_out); end
    endtask

    task automatic test_io();
        run_txn(1'b0, 1'b1, 16'hFF10, 16'h00FF, 1'b0, 1'b0);
        checks++; if (r_lat !== 3 || r_err !== 1'b0 || r_iow_cnt !== 1 || r_ior_cnt !== 0 || r_we_cnt !== 0) begin
            failures++; $display("FAIL io_wr got lat=%0d err=%b iow=%0d ior=%0d we=%0d exp 3 0 1 0 0", r_lat, r_err, r_iow_cnt, r_ior_cnt, r_we_cnt); end
        checks++; if (r_ioaddr !== 8'h10 || r_iodata !== 16'h00FF) begin
            failures++; $display("FAIL io_wr_bus got addr=%h data=%h exp 10 00ff", r_ioaddr, r_iodata); end
        checks++; if (bus_if.data_out !== 16'h1234) begin
            failures++; $display("FAIL io_wr_hold got=%h exp=1234", bus_if.data_out); end
        io_data_in = 16'h5A5A;
        run_txn(1'b1, 1'b0, 16'hFF20, 16'h0000, 1'b0, 1'b0);
        checks++; if (r_lat !== 3 || r_ior_cnt !== 1 || r_iow_cnt !== 0 || r_ioaddr !== 8'h20) begin
            failures++; $display("FAIL io_rd got lat=%0d ior=%0d iow=%0d addr=%h exp 3 1 0 20", r_lat, r_ior_cnt, r_iow_cnt, r_ioaddr); end
        checks++; if (bus_if.data_out !== 16'h5A5A) begin
            failures++; $display("FAIL io_rd_data got=%h exp=5a5a", bus_if.data_out); end
        io_data_in = 16'h12C8;
        run_txn(1'b1, 1'b0, 16'hFF21, 16'h0000, 1'b1, 1'b1);
        checks++; if (bus_if.data_out !== 16'h0012) begin
            failures++; $display("FAIL io_rd_byte got=%h exp=0012", bus_if.data_out); end
        io_data_in = 16'h5A5A;
        run_txn(1'b1, 1'b0, 16'hFF20, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        bus_if.address = 16'h0300; bus_if.data_in = 16'hDEAD;
        bus_if.byte_access = 1'b0; bus_if.write_start = 1'b1;
        @(posedge clk);
        #1 bus_if.write_start = 1'b0;
        #1;
        checks++; if (ram_write_enable !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre got we=%b exp 1", ram_write_enable); end
        reset_n = 1'b0;
        #1;
        checks++; if (ram_write_enable !== 1'b0 || ram_write_mask !== 2'b11 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            failures++; $display("FAIL rst_mid_ctrl got we=%b mask=%b busy=%b done=%b exp 0 11 0 0", ram_write_enable, ram_write_mask, bus_if.busy, bus_if.done); end
        checks++; if (bus_if.data_out !== 16'h0000 || ram_address !== 12'h000 || io_address !== 8'h00) begin
            failures++; $display("FAIL rst_mid_state got data=%h ram=%h io=%h exp 0000 000 00", bus_if.data_out, ram_address, io_address); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_if.done) done_cnt++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_if.done) done_cnt++;
        end
        checks++; if (done_cnt !== 0) begin
            failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_after_reset();
        run_txn(1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 1'b0);
        checks++; if (r_lat !== 3 || r_err !== 1'b0 || bus_if.data_out !== 16'h0000) begin
            failures++; $display("FAIL after_rst_aborted got lat=%0d err=%b data=%h exp 3 0 0000", r_lat, r_err, bus_if.data_out); end
        run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0);
        checks++; if (r_lat !== 3 || bus_if.data_out !== 16'h1234) begin
            failures++; $display("FAIL after_rst_read got lat=%0d data=%h exp 3 1234", r_lat, bus_if.data_out); end
    endtask

    initial begin
        bus_if.address     = '0;
        bus_if.data_in     = '0;
        bus_if.byte_access = 1'b0;
        bus_if.sign_extend = 1'b0;
        bus_if.read_start  = 1'b0;
        bus_if.write_start = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_rw();
        test_errors();
        test_busy_ignore();
        test_io();
        test_reset_mid_write();
        test_after_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
